// File: rtl/button_debouncer.sv
// button_debouncer
//   Turns a raw, bouncing push-button pin into a debounced level plus
//   single-cycle press/release pulses. The pin is synchronised through a
//   SYNC_STAGES flop chain. An edge is accepted only after DEBOUNCE_CYCLES
//   consecutive stable samples.
//   Optional feature macro HOLD_REPEAT_EN: while the button is held, an extra
//   press_pulse is emitted every REPEAT_CYCLES cycles.
module button_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press_pulse,
  output logic release_pulse,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject parameter values that would break the counters or the synchroniser.
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("button_debouncer: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("button_debouncer: DEBOUNCE_CYCLES must be >= 2");
  end
  if (REPEAT_CYCLES < 2) begin : g_bad_repeat
    $error("button_debouncer: REPEAT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_HIGH = 2'd1,
    HIGH      = 2'd2,
    WAIT_LOW  = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_chain;
  logic                   sync;
  state_t                 state;
  logic [CNT_W-1:0]       cnt;

`ifdef HOLD_REPEAT_EN
  localparam int RCNT_W = $clog2(REPEAT_CYCLES);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REPEAT_CYCLES - 1);
  logic [RCNT_W-1:0] rcnt;
`endif

  // Shift the asynchronous pin through the synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_chain <= '0;
    end else begin
      sync_chain <= {sync_chain[SYNC_STAGES-2:0], btn_raw};
    end
  end

  assign sync = sync_chain[SYNC_STAGES-1];

  // Debounce FSM; pulses default low so each one lasts exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      level         <= 1'b0;
`ifdef HOLD_REPEAT_EN
      rcnt          <= '0;
`endif
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (sync) begin
            state <= WAIT_HIGH;
            cnt   <= '0;
          end
        end
        WAIT_HIGH: begin
          if (!sync) begin
            // Bounce: fall back without any pulse.
            state <= IDLE;
          end else if (cnt == CNT_LAST) begin
            state       <= HIGH;
            press_pulse <= 1'b1;
            level       <= 1'b1;
`ifdef HOLD_REPEAT_EN
            rcnt        <= '0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (!sync) begin
            state <= WAIT_LOW;
            cnt   <= '0;
          end
`ifdef HOLD_REPEAT_EN
          else if (rcnt == RCNT_LAST) begin
            // Held long enough for another auto-repeat press.
            press_pulse <= 1'b1;
            rcnt        <= '0;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
`endif
        end
        WAIT_LOW: begin
          if (sync) begin
            // Release glitch: still pressed, no new press pulse.
            state <= HIGH;
`ifdef HOLD_REPEAT_EN
            rcnt  <= '0;
`endif
          end else if (cnt == CNT_LAST) begin
            state         <= IDLE;
            release_pulse <= 1'b1;
            level         <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          level <= 1'b0;
        end
      endcase
    end
  end

endmodule
